// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU load/store port vs. word-burst DMA with starvation bound.
// Optional burst abort when DMEM_ARB_ABORT_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_sel,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_start,
    input  logic              dma_dir,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_wdata_pop,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_busy,
    output logic              dma_done,
`ifdef DMEM_ARB_ABORT_EN
    input  logic              dma_abort,
    output logic              dma_aborted,
`endif
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              cpu_grant;
    logic              dma_grant;
`ifdef DMEM_ARB_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        starve_d  = starve_q;
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
`ifdef DMEM_ARB_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cpu_grant = cpu_req;
                if (dma_start) begin
                    if (dma_len != '0) begin
                        addr_d   = {dma_base[ADDR_W-1:2], 2'b00};
                        rem_d    = dma_len;
                        dir_d    = dma_dir;
                        starve_d = '0;
                        state_d  = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // CPU may win only while it has not used up its starvation budget
                if (cpu_req && (starve_q < SW'(STARVE_MAX))) begin
                    cpu_grant = 1'b1;
                    starve_d  = starve_q + SW'(1);
                end else begin
                    dma_grant = 1'b1;
                    starve_d  = '0;
                    addr_d    = addr_q + ADDR_W'(4);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = DONE;
                end
`ifdef DMEM_ARB_ABORT_EN
                if (dma_abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
`endif
            end
            DONE: begin
                cpu_grant = cpu_req;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            starve_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
`ifdef DMEM_ARB_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            starve_q  <= starve_d;
            rvalid_q  <= dma_grant & ~dir_q;
            if (dma_grant && !dir_q)
                rdata_q <= mem_rdata;
`ifdef DMEM_ARB_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = 4'h0;
        mem_wdata = '0;
        if (dma_grant) begin
            mem_ce    = 1'b1;
            mem_we    = dir_q;
            mem_addr  = addr_q;
            mem_sel   = 4'hF;
            mem_wdata = dma_wdata;
        end else if (cpu_grant) begin
            mem_ce    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_sel   = cpu_sel;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_stall     = cpu_req & ~cpu_grant;
    assign cpu_rdata     = (cpu_grant && !cpu_we) ? mem_rdata : '0;
    assign dma_wdata_pop = dma_grant & dir_q;
    assign dma_rdata     = rdata_q;
    assign dma_rvalid    = rvalid_q;
    assign dma_busy      = (state_q != IDLE);
    assign dma_done      = (state_q == DONE);
`ifdef DMEM_ARB_ABORT_EN
    assign dma_aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected DMA writes/reads queued at stimulus,
// checked by a monitor as the memory port and dma_rvalid produce them.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_sel;
    logic        cpu_stall;
    logic        dma_start, dma_dir;
    logic [31:0] dma_base, dma_wdata, dma_rdata;
    logic [7:0]  dma_len;
    logic        dma_wdata_pop, dma_rvalid, dma_busy, dma_done;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;
`ifdef DMEM_ARB_ABORT_EN
    logic        dma_abort, dma_aborted;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [256];
    logic [31:0] src [16];
    int          sidx;
    logic [63:0] exp_wr [$];
    logic [31:0] exp_rd [$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(8), .STARVE_MAX(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base),
        .dma_len(dma_len), .dma_wdata(dma_wdata),
        .dma_wdata_pop(dma_wdata_pop), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
`ifdef DMEM_ARB_ABORT_EN
        .dma_abort(dma_abort), .dma_aborted(dma_aborted),
`endif
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];
    assign dma_wdata = src[sidx];

    always @(posedge clk) begin
        if (mem_ce && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_sel[b])
                    mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (dma_wdata_pop)
            sidx <= sidx + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every memory write and every dma_rvalid must match the queue head
    always @(negedge clk) begin
        if (rst && mem_ce && mem_we) begin
            if (exp_wr.size() == 0)
                chk("wr_extra", {mem_addr, mem_wdata}, 64'h0);
            else
                chk("wr_beat", {mem_addr, mem_wdata}, exp_wr.pop_front());
        end
        if (dma_rvalid) begin
            if (exp_rd.size() == 0)
                chk("rd_extra", dma_rdata, 64'h0);
            else
                chk("rd_beat", dma_rdata, exp_rd.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [31:0] base,
                         input logic [7:0] len);
        dma_start = 1'b1;
        dma_dir   = dir;
        dma_base  = base;
        dma_len   = len;
        step();
        dma_start = 1'b0;
    endtask

    logic [5:0] stall_pat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        src = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hC0, 32'hC1,
                32'hC2, 32'hC3, 32'hE0, 32'hD0, 32'hD1, 32'hD2, 32'h0,
                32'h0, 32'h0};
        sidx      = 0;
        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_sel   = 4'h0;
        cpu_wdata = '0;
        dma_start = 1'b0;
        dma_dir   = 1'b0;
        dma_base  = '0;
        dma_len   = '0;
`ifdef DMEM_ARB_ABORT_EN
        dma_abort = 1'b0;
`endif
        #12;
        chk("rst_busy", dma_busy, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        chk("rst_ce", mem_ce, 0);
        step();
        rst = 1'b1;
        step();

        // Write burst, CPU idle
        exp_wr.push_back({32'h100, 32'hA0});
        exp_wr.push_back({32'h104, 32'hA1});
        exp_wr.push_back({32'h108, 32'hA2});
        start(1'b1, 32'h100, 8'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("wb_pop%0d", i), dma_wdata_pop, i < 3);
            chk($sformatf("wb_done%0d", i), dma_done, i == 3);
            chk($sformatf("wb_busy%0d", i), dma_busy, i < 4);
`ifdef DMEM_ARB_ABORT_EN
            chk($sformatf("wb_abt%0d", i), dma_aborted, 0);
`endif
            step();
        end

        // Read-back
        exp_rd.push_back(32'hA0);
        exp_rd.push_back(32'hA1);
        exp_rd.push_back(32'hA2);
        start(1'b0, 32'h100, 8'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rb_stall%0d", i), cpu_stall, 0);
            chk($sformatf("rb_rv%0d", i), dma_rvalid, (i >= 1 && i <= 3));
            chk($sformatf("rb_done%0d", i), dma_done, i == 3);
            step();
        end

        // Starvation with STARVE_MAX = 2
        stall_pat = 6'b100100;
        exp_rd.push_back(32'hA0);
        exp_rd.push_back(32'hA1);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h108;
        cpu_sel  = 4'hF;
        start(1'b0, 32'h100, 8'd2);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) begin
                chk($sformatf("sv_stall%0d", i), cpu_stall, stall_pat[i]);
                chk($sformatf("sv_rdata%0d", i), cpu_rdata,
                    stall_pat[i] ? 32'h0 : 32'hA2);
                chk($sformatf("sv_addr%0d", i), mem_addr,
                    stall_pat[i] ? (i == 2 ? 32'h100 : 32'h104) : 32'h108);
            end else begin
                chk("sv_done", dma_done, 1);
                chk("sv_stall_done", cpu_stall, 0);
            end
            step();
        end
        cpu_req = 1'b0;
        step();

        // Zero-length burst
        start(1'b1, 32'h200, 8'd0);
        @(negedge clk);
        chk("z_done", dma_done, 1);
        chk("z_ce", mem_ce, 0);
        chk("z_pop", dma_wdata_pop, 0);
        step();
        @(negedge clk);
        chk("z_done_off", dma_done, 0);
        chk("z_busy_off", dma_busy, 0);
        step();

        // Address wrap
        exp_wr.push_back({32'hFFFFFFFC, 32'hB0});
        exp_wr.push_back({32'h00000000, 32'hB1});
        start(1'b1, 32'hFFFFFFFE, 8'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) chk("wr_addr0", mem_addr, 32'hFFFFFFFC);
            if (i == 1) chk("wr_addr1", mem_addr, 32'h00000000);
            if (i < 2) chk($sformatf("wr_sel%0d", i), mem_sel, 4'hF);
            chk($sformatf("wr_done%0d", i), dma_done, i == 2);
            step();
        end
        step();

        // Reset mid-burst after one of four beats
        exp_wr.push_back({32'h200, 32'hC0});
        start(1'b1, 32'h200, 8'd4);
        @(negedge clk);
        chk("rm_pop0", dma_wdata_pop, 1);
        step();
        rst  = 1'b0;
        sidx = 9;
        #1;
        chk("rm_busy", dma_busy, 0);
        chk("rm_ce", mem_ce, 0);
        chk("rm_we", mem_we, 0);
        chk("rm_addr", mem_addr, 0);
        chk("rm_pop", dma_wdata_pop, 0);
        chk("rm_done", dma_done, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rm_idle%0d", i), {dma_busy, dma_done}, 0);
            step();
        end
        exp_wr.push_back({32'h300, 32'hE0});
        start(1'b1, 32'h300, 8'd1);
        @(negedge clk);
        chk("rm_new_pop", dma_wdata_pop, 1);
        step();
        @(negedge clk);
        chk("rm_new_done", dma_done, 1);
        step();
        step();

`ifdef DMEM_ARB_ABORT_EN
        sidx = 10;
        exp_wr.push_back({32'h400, 32'hD0});
        exp_wr.push_back({32'h404, 32'hD1});
        exp_wr.push_back({32'h408, 32'hD2});
        start(1'b1, 32'h400, 8'd10);
        for (int i = 0; i < 5; i++) begin
            dma_abort = (i == 2);
            @(negedge clk);
            chk($sformatf("ab_pop%0d", i), dma_wdata_pop, i < 3);
            chk($sformatf("ab_done%0d", i), dma_done, i == 3);
            chk($sformatf("ab_abt%0d", i), dma_aborted, i == 3);
            step();
        end
        dma_abort = 1'b0;
`endif

        chk("wr_q_empty", exp_wr.size(), 0);
        chk("rd_q_empty", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
